calendar_set_ctrl: RTL and testbench

Controller that owns the date, month and year counters of the clock's calendar section. In RUN mode it time-shares the common databus by rotating the counters' `enable` lines. In SET mode it runs a button-driven edit sequence: stage year, then month, then date. It then commits all three to the counters with one simultaneous load pulse. Day limit, leap year and month wrap are resolved here, so the counters stay simple load/increment registers.

---
 rtl/cal_pkg.sv | 25 ++
 rtl/cal_days_in_month.sv | 19 +
 rtl/calendar_set_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_calendar_set_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared types and constants for the calendar set controller and its helpers.
package cal_pkg;

    localparam int DATE_W    = 5;
    localparam int MONTH_W   = 4;
    localparam int YEAR_W    = 7;
    localparam int MONTH_MAX = 12;
    localparam int YEAR_MOD  = 100;

    typedef enum logic [2:0] {
        S_RUN        = 3'd0,
        S_EDIT_YEAR  = 3'd1,
        S_EDIT_MONTH = 3'd2,
        S_EDIT_DATE  = 3'd3,
        S_COMMIT     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE  = 2'd0,
        FIELD_YEAR  = 2'd1,
        FIELD_MONTH = 2'd2,
        FIELD_DATE  = 2'd3
    } field_t;

endpackage

// File: rtl/cal_days_in_month.sv
// Number of days in a month for years 2000..2099; also reused by the date counter's rollover.
module cal_days_in_month
    import cal_pkg::*;
(
    input  logic [MONTH_W-1:0] i_month,
    input  logic [YEAR_W-1:0]  i_year,
    output logic [DATE_W-1:0]  o_days
);

    // Within 2000..2099 every year divisible by four is a leap year, including 2000.
    always_comb begin
        case (i_month)
            4'd2:                      o_days = (i_year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   o_days = 5'd30;
            default:                   o_days = 5'd31;
        endcase
    end

endmodule

// File: rtl/calendar_set_ctrl.sv
// Owns the calendar counters: rotates databus ownership in RUN and runs the
// year/month/date edit sequence that ends in one simultaneous load pulse.
module calendar_set_ctrl
    import cal_pkg::*;
#(
    parameter int SCAN_DIV  = 4,
    parameter int TIMEOUT   = 1000,
    parameter int BLINK_DIV = 8
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               mode_btn,
    input  logic               up_btn,
    input  logic               down_btn,
    input  logic [DATE_W-1:0]  cur_date,
    input  logic [MONTH_W-1:0] cur_month,
    input  logic [YEAR_W-1:0]  cur_year,
    output logic               date_en,
    output logic               month_en,
    output logic               year_en,
    output logic               date_load,
    output logic               month_load,
    output logic               year_load,
    output logic [DATE_W-1:0]  date_data,
    output logic [MONTH_W-1:0] month_data,
    output logic [YEAR_W-1:0]  year_data,
    output logic [1:0]         edit_field,
    output logic               blink
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int IDLE_W  = (TIMEOUT   > 1) ? $clog2(TIMEOUT)   : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // Enable vector is {date, month, year}.
    localparam logic [2:0] EN_DATE  = 3'b100;
    localparam logic [2:0] EN_MONTH = 3'b010;
    localparam logic [2:0] EN_YEAR  = 3'b001;
    localparam logic [2:0] EN_NONE  = 3'b000;

    localparam logic [YEAR_W-1:0]  YEAR_LAST  = YEAR_W'(YEAR_MOD - 1);
    localparam logic [MONTH_W-1:0] MONTH_LAST = MONTH_W'(MONTH_MAX);

    state_t               r_state;
    field_t               r_field;
    logic [2:0]           r_en;
    logic                 r_load;
    logic [SCAN_W-1:0]    r_scan;
    logic [IDLE_W-1:0]    r_idle;
    logic [BLINK_W-1:0]   r_blink_cnt;
    logic                 r_blink;
    logic [DATE_W-1:0]    r_date_data;
    logic [MONTH_W-1:0]   r_month_data;
    logic [YEAR_W-1:0]    r_year_data;

    logic                 w_up;
    logic                 w_down;
    logic [DATE_W-1:0]    w_days;

    assign w_up   = up_btn & ~down_btn;
    assign w_down = down_btn & ~up_btn;

    cal_days_in_month u_days (
        .i_month (r_month_data),
        .i_year  (r_year_data),
        .o_days  (w_days)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state      <= S_RUN;
            r_field      <= FIELD_NONE;
            r_en         <= EN_DATE;
            r_load       <= 1'b0;
            r_scan       <= '0;
            r_idle       <= '0;
            r_blink_cnt  <= '0;
            r_blink      <= 1'b0;
            r_date_data  <= DATE_W'(1);
            r_month_data <= MONTH_W'(1);
            r_year_data  <= '0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (mode_btn) begin
                        r_state      <= S_EDIT_YEAR;
                        r_field      <= FIELD_YEAR;
                        r_en         <= EN_YEAR;
                        r_idle       <= '0;
                        r_blink_cnt  <= '0;
                        r_blink      <= 1'b0;
                        r_date_data  <= cur_date;
                        r_month_data <= cur_month;
                        r_year_data  <= cur_year;
                    end else if (r_scan == SCAN_LAST) begin
                        r_scan <= '0;
                        r_en   <= {r_en[0], r_en[2:1]};
                    end else begin
                        r_scan <= r_scan + SCAN_W'(1);
                    end
                end
                S_EDIT_YEAR, S_EDIT_MONTH, S_EDIT_DATE: begin
                    if (r_blink_cnt == BLINK_LAST) begin
                        r_blink_cnt <= '0;
                        r_blink     <= ~r_blink;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
                    end
                    // Later assignments below override the blink update on state changes.
                    if (mode_btn) begin
                        r_idle      <= '0;
                        r_blink_cnt <= '0;
                        r_blink     <= 1'b0;
                        case (r_state)
                            S_EDIT_YEAR: begin
                                r_state <= S_EDIT_MONTH;
                                r_field <= FIELD_MONTH;
                                r_en    <= EN_MONTH;
                            end
                            S_EDIT_MONTH: begin
                                r_state <= S_EDIT_DATE;
                                r_field <= FIELD_DATE;
                                r_en    <= EN_DATE;
                                if (r_date_data > w_days)
                                    r_date_data <= w_days;
                            end
                            default: begin
                                r_state <= S_COMMIT;
                                r_field <= FIELD_NONE;
                                r_en    <= EN_NONE;
                                r_load  <= 1'b1;
                            end
                        endcase
                    end else if (w_up || w_down) begin
                        r_idle <= '0;
                        case (r_state)
                            S_EDIT_YEAR: begin
                                if (w_up)
                                    r_year_data <= (r_year_data == YEAR_LAST) ? '0 : r_year_data + YEAR_W'(1);
                                else
                                    r_year_data <= (r_year_data == '0) ? YEAR_LAST : r_year_data - YEAR_W'(1);
                            end
                            S_EDIT_MONTH: begin
                                if (w_up)
                                    r_month_data <= (r_month_data >= MONTH_LAST) ? MONTH_W'(1) : r_month_data + MONTH_W'(1);
                                else
                                    r_month_data <= (r_month_data <= MONTH_W'(1)) ? MONTH_LAST : r_month_data - MONTH_W'(1);
                            end
                            default: begin
                                if (w_up)
                                    r_date_data <= (r_date_data >= w_days) ? DATE_W'(1) : r_date_data + DATE_W'(1);
                                else
                                    r_date_data <= (r_date_data <= DATE_W'(1)) ? w_days : r_date_data - DATE_W'(1);
                            end
                        endcase
                    end else if (r_idle == IDLE_LAST) begin
                        r_state     <= S_RUN;
                        r_field     <= FIELD_NONE;
                        r_en        <= EN_DATE;
                        r_scan      <= '0;
                        r_idle      <= '0;
                        r_blink_cnt <= '0;
                        r_blink     <= 1'b0;
                    end else begin
                        r_idle <= r_idle + IDLE_W'(1);
                    end
                end
                S_COMMIT: begin
                    r_state <= S_RUN;
                    r_field <= FIELD_NONE;
                    r_en    <= EN_DATE;
                    r_scan  <= '0;
                end
                default: begin
                    r_state <= S_RUN;
                    r_field <= FIELD_NONE;
                    r_en    <= EN_DATE;
                    r_scan  <= '0;
                end
            endcase
        end
    end

    assign date_en    = r_en[2];
    assign month_en   = r_en[1];
    assign year_en    = r_en[0];
    assign date_load  = r_load;
    assign month_load = r_load;
    assign year_load  = r_load;
    assign date_data  = r_date_data;
    assign month_data = r_month_data;
    assign year_data  = r_year_data;
    assign edit_field = r_field;
    assign blink      = r_blink;

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Self-checking bench for calendar_set_ctrl: directed scenarios plus random
// button traffic compared against a behavioural calendar model.
module tb_calendar_set_ctrl;

    localparam int SCAN_DIV  = 4;
    localparam int TIMEOUT   = 1000;
    localparam int BLINK_DIV = 8;

    // Packed view: {en[3], load[3], date, month, year, field, blink}.
    localparam logic [24:0] RESET_VEC = {3'b100, 3'b000, 5'd1, 4'd1, 7'd0, 2'd0, 1'b0};

    logic       clk;
    logic       clear;
    logic       mode_btn;
    logic       up_btn;
    logic       down_btn;
    logic [4:0] cur_date;
    logic [3:0] cur_month;
    logic [6:0] cur_year;
    logic       date_en, month_en, year_en;
    logic       date_load, month_load, year_load;
    logic [4:0] date_data;
    logic [3:0] month_data;
    logic [6:0] year_data;
    logic [1:0] edit_field;
    logic       blink;

    logic [24:0] dutVec;

    int nChecks;
    int nErrors;

    // Model: 0=run, 1=edit year, 2=edit month, 3=edit date, 4=commit.
    int mState, mDate, mMonth, mYear, mRunCycles, mStateCycles, mIdle;

    calendar_set_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .TIMEOUT   (TIMEOUT),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .mode_btn   (mode_btn),
        .up_btn     (up_btn),
        .down_btn   (down_btn),
        .cur_date   (cur_date),
        .cur_month  (cur_month),
        .cur_year   (cur_year),
        .date_en    (date_en),
        .month_en   (month_en),
        .year_en    (year_en),
        .date_load  (date_load),
        .month_load (month_load),
        .year_load  (year_load),
        .date_data  (date_data),
        .month_data (month_data),
        .year_data  (year_data),
        .edit_field (edit_field),
        .blink      (blink)
    );

    assign dutVec = {date_en, month_en, year_en, date_load, month_load, year_load,
                     date_data, month_data, year_data, edit_field, blink};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int daysIn(int month, int year);
        if (month == 2) return (year % 4 == 0) ? 29 : 28;
        if (month == 4 || month == 6 || month == 9 || month == 11) return 30;
        return 31;
    endfunction

    function automatic logic [24:0] expVec();
        logic [2:0] en;
        logic       editing;
        int         owner;
        owner   = (mRunCycles / SCAN_DIV) % 3;
        editing = (mState >= 1 && mState <= 3);
        case (mState)
            0:       en = (owner == 0) ? 3'b100 : (owner == 1) ? 3'b010 : 3'b001;
            1:       en = 3'b001;
            2:       en = 3'b010;
            3:       en = 3'b100;
            default: en = 3'b000;
        endcase
        return {en, (mState == 4) ? 3'b111 : 3'b000, 5'(mDate), 4'(mMonth), 7'(mYear),
                editing ? 2'(mState) : 2'd0,
                editing ? 1'((mStateCycles / BLINK_DIV) % 2) : 1'b0};
    endfunction

    task automatic modelReset();
        mState = 0; mDate = 1; mMonth = 1; mYear = 0;
        mRunCycles = 0; mStateCycles = 0; mIdle = 0;
    endtask

    task automatic modelStep(input logic m, input logic u, input logic d);
        int mx;
        case (mState)
            0: begin
                if (m) begin
                    mDate = int'(cur_date); mMonth = int'(cur_month); mYear = int'(cur_year);
                    mState = 1; mStateCycles = 0; mIdle = 0;
                end else begin
                    mRunCycles++;
                end
            end
            1, 2, 3: begin
                mx = daysIn(mMonth, mYear);
                if (m) begin
                    if (mState == 2 && mDate > mx) mDate = mx;
                    mState++; mStateCycles = 0; mIdle = 0;
                end else if (u != d) begin
                    mIdle = 0; mStateCycles++;
                    if (mState == 1) mYear  = u ? (mYear + 1) % 100 : (mYear + 99) % 100;
                    if (mState == 2) mMonth = u ? mMonth % 12 + 1 : (mMonth + 10) % 12 + 1;
                    if (mState == 3) mDate  = u ? mDate % mx + 1 : (mDate + mx - 2) % mx + 1;
                end else begin
                    mIdle++; mStateCycles++;
                    if (mIdle >= TIMEOUT) begin
                        mState = 0; mRunCycles = 0;
                    end
                end
            end
            default: begin
                mState = 0; mRunCycles = 0;
            end
        endcase
    endtask

    task automatic tick(input logic m, input logic u, input logic d);
        mode_btn = m; up_btn = u; down_btn = d;
        @(posedge clk);
        modelStep(m, u, d);
        #1;
        mode_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0;
    endtask

    task automatic applyClear();
        clear = 1'b1;
        #2;
        modelReset();
        clear = 1'b0;
    endtask

    task automatic setCur(input int d, input int m, input int y);
        cur_date = 5'(d); cur_month = 4'(m); cur_year = 7'(y);
    endtask

    task automatic test_reset();
        logic [2:0] expEn;
        @(posedge clk);
        #1;
        nChecks++;
        if (dutVec !== RESET_VEC) begin
            nErrors++;
            $display("[TB] FAIL reset_held: got %h expected %h", dutVec, RESET_VEC);
        end
        applyClear();
        for (int i = 1; i <= 13; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            expEn = (i < 4) ? 3'b100 : (i < 8) ? 3'b010 : (i < 12) ? 3'b001 : 3'b100;
            nChecks++;
            if ({date_en, month_en, year_en, date_load, month_load, year_load} !== {expEn, 3'b000}) begin
                nErrors++;
                $display("[TB] FAIL scan_cycle%0d: got %b expected %b", i,
                         {date_en, month_en, year_en, date_load, month_load, year_load}, {expEn, 3'b000});
            end
        end
    endtask

    task automatic test_commit_sequence();
        setCur(15, 6, 23);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        nChecks++;
        if (year_data !== 7'd25 || edit_field !== 2'd1 || {date_en, month_en, year_en} !== 3'b001) begin
            nErrors++;
            $display("[TB] FAIL year_edit: got y=%0d f=%0d en=%b expected y=25 f=1 en=001",
                     year_data, edit_field, {date_en, month_en, year_en});
        end
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        nChecks++;
        if ({date_load, month_load, year_load} !== 3'b000 || edit_field !== 2'd3) begin
            nErrors++;
            $display("[TB] FAIL pre_commit: got load=%b f=%0d expected load=000 f=3",
                     {date_load, month_load, year_load}, edit_field);
        end
        tick(1'b1, 1'b0, 1'b0);
        nChecks++;
        if ({date_load, month_load, year_load} !== 3'b111 || date_data !== 5'd15 ||
            month_data !== 4'd5 || year_data !== 7'd25 || {date_en, month_en, year_en} !== 3'b000) begin
            nErrors++;
            $display("[TB] FAIL commit: got load=%b d=%0d m=%0d y=%0d en=%b expected load=111 d=15 m=5 y=25 en=000",
                     {date_load, month_load, year_load}, date_data, month_data, year_data,
                     {date_en, month_en, year_en});
        end
        tick(1'b1, 1'b1, 1'b0);
        nChecks++;
        if ({date_en, month_en, year_en, date_load, month_load, year_load} !== 6'b100000 || edit_field !== 2'd0) begin
            nErrors++;
            $display("[TB] FAIL post_commit: got en/load=%b f=%0d expected 100000 f=0",
                     {date_en, month_en, year_en, date_load, month_load, year_load}, edit_field);
        end
    endtask

    task automatic test_clamp();
        int yr[2];
        int expDays[2];
        yr[0] = 24; yr[1] = 23; expDays[0] = 29; expDays[1] = 28;
        for (int k = 0; k < 2; k++) begin
            applyClear();
            setCur(31, 1, yr[k]);
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b0, 1'b1, 1'b0);
            tick(1'b1, 1'b0, 1'b0);
            nChecks++;
            if (date_data !== 5'(expDays[k]) || month_data !== 4'd2 || edit_field !== 2'd3) begin
                nErrors++;
                $display("[TB] FAIL clamp_y%0d: got d=%0d m=%0d f=%0d expected d=%0d m=2 f=3",
                         yr[k], date_data, month_data, edit_field, expDays[k]);
            end
        end
    endtask

    task automatic test_wrap();
        applyClear();
        setCur(30, 4, 99);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        nChecks++;
        if (year_data !== 7'd0) begin
            nErrors++;
            $display("[TB] FAIL year_wrap_up: got %0d expected 0", year_data);
        end
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        nChecks++;
        if (date_data !== 5'd1) begin
            nErrors++;
            $display("[TB] FAIL date_wrap_up: got %0d expected 1", date_data);
        end
        tick(1'b0, 1'b0, 1'b1);
        nChecks++;
        if (date_data !== 5'd30) begin
            nErrors++;
            $display("[TB] FAIL date_wrap_down: got %0d expected 30", date_data);
        end
        tick(1'b0, 1'b1, 1'b1);
        nChecks++;
        if (date_data !== 5'd30 || edit_field !== 2'd3) begin
            nErrors++;
            $display("[TB] FAIL up_down_ignored: got d=%0d f=%0d expected d=30 f=3", date_data, edit_field);
        end
        applyClear();
        setCur(10, 1, 50);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        nChecks++;
        if (month_data !== 4'd12) begin
            nErrors++;
            $display("[TB] FAIL month_wrap_down: got %0d expected 12", month_data);
        end
        tick(1'b0, 1'b1, 1'b0);
        nChecks++;
        if (month_data !== 4'd1) begin
            nErrors++;
            $display("[TB] FAIL month_wrap_up: got %0d expected 1", month_data);
        end
    endtask

    task automatic test_timeout();
        applyClear();
        setCur(5, 5, 5);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < TIMEOUT; i++) begin
            if (i == 500) tick(1'b0, 1'b1, 1'b1);
            else          tick(1'b0, 1'b0, 1'b0);
            nChecks++;
            if (dutVec !== expVec()) begin
                nErrors++;
                $display("[TB] FAIL idle_cycle%0d: got %h expected %h", i, dutVec, expVec());
            end
            if (i == BLINK_DIV || i == 2 * BLINK_DIV) begin
                nChecks++;
                if (blink !== ((i == BLINK_DIV) ? 1'b1 : 1'b0)) begin
                    nErrors++;
                    $display("[TB] FAIL blink_at%0d: got %b expected %b", i, blink, (i == BLINK_DIV));
                end
            end
        end
        nChecks++;
        if (edit_field !== 2'd1 || year_data !== 7'd5) begin
            nErrors++;
            $display("[TB] FAIL before_timeout: got f=%0d y=%0d expected f=1 y=5", edit_field, year_data);
        end
        tick(1'b0, 1'b0, 1'b0);
        nChecks++;
        if ({date_en, month_en, year_en, date_load, month_load, year_load} !== 6'b100000 ||
            edit_field !== 2'd0 || blink !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL timeout_exit: got en/load=%b f=%0d b=%b expected 100000 f=0 b=0",
                     {date_en, month_en, year_en, date_load, month_load, year_load}, edit_field, blink);
        end
    endtask

    task automatic test_clear_mid();
        applyClear();
        setCur(20, 7, 30);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        applyClear();
        nChecks++;
        if (dutVec !== RESET_VEC) begin
            nErrors++;
            $display("[TB] FAIL clear_in_date_edit: got %h expected %h", dutVec, RESET_VEC);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            nChecks++;
            if ({date_load, month_load, year_load} !== 3'b000) begin
                nErrors++;
                $display("[TB] FAIL load_after_clear%0d: got %b expected 000", i, {date_load, month_load, year_load});
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
        nChecks++;
        if ({date_load, month_load, year_load} !== 3'b111) begin
            nErrors++;
            $display("[TB] FAIL commit_before_clear: got %b expected 111", {date_load, month_load, year_load});
        end
        applyClear();
        nChecks++;
        if (dutVec !== RESET_VEC) begin
            nErrors++;
            $display("[TB] FAIL clear_in_commit: got %h expected %h", dutVec, RESET_VEC);
        end
    endtask

    task automatic test_random();
        logic m, u, d;
        applyClear();
        for (int i = 0; i < 4000; i++) begin
            setCur(int'($urandom_range(1, 31)), int'($urandom_range(1, 12)), int'($urandom_range(0, 99)));
            m = ($urandom_range(0, 5) == 0);
            u = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 2) == 0);
            tick(m, u, d);
            nChecks++;
            if (dutVec !== expVec()) begin
                nErrors++;
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, dutVec, expVec());
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nChecks  = 0;
        nErrors  = 0;
        clear    = 1'b1;
        mode_btn = 1'b0;
        up_btn   = 1'b0;
        down_btn = 1'b0;
        setCur(1, 1, 0);
        modelReset();
        $display("[TB] starting calendar_set_ctrl bench");
        test_reset();
        test_commit_sequence();
        test_clamp();
        test_wrap();
        test_timeout();
        test_clear_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
